// File: rtl/reverse_arbiter.sv
// rtl/reverse_arbiter.sv - two-requester round-robin arbiter with a registered bit-reversed result
// One output slot; a new operand is accepted whenever that slot is empty or being drained this cycle.
module reverse_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] din0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din1,
  output logic             ack1,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             dout_src,
  input  logic             dout_ready,
  output logic [15:0]      xfer_cnt
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             dout_src_q, dout_src_d;
  logic             last_grant_q, last_grant_d;
  logic [15:0]      xfer_cnt_q, xfer_cnt_d;

  logic             grant0, grant1;
  logic             slot_free, load, handshake;
  logic [WIDTH-1:0] din_g, din_rev;

  // On a tie, requester 0 wins unless it was the last one served.
  always_comb begin
    grant0    = req0 & (~req1 | last_grant_q);
    grant1    = req1 & ~grant0;
    slot_free = ~dout_valid_q | dout_ready;
    load      = slot_free & (req0 | req1) & ~rst;
    ack0      = load & grant0;
    ack1      = load & grant1;
    handshake = dout_valid_q & dout_ready;
    din_g     = grant1 ? din1 : din0;
  end

  always_comb begin
    din_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      din_rev[i] = din_g[WIDTH-1-i];
    end
  end

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_src_d   = dout_src_q;
    last_grant_d = last_grant_q;
    xfer_cnt_d   = xfer_cnt_q;
    if (handshake) begin
      xfer_cnt_d   = xfer_cnt_q + 16'd1;
      dout_valid_d = 1'b0;
    end
    if (load) begin
      dout_d       = din_rev;
      dout_src_d   = grant1;
      dout_valid_d = 1'b1;
      last_grant_d = grant1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_src_q   <= 1'b0;
      last_grant_q <= 1'b1;
      xfer_cnt_q   <= 16'd0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_src_q   <= dout_src_d;
      last_grant_q <= last_grant_d;
      xfer_cnt_q   <= xfer_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_src   = dout_src_q;
  assign xfer_cnt   = xfer_cnt_q;

endmodule

// File: tb/tb_reverse_arbiter.sv
// tb/tb_reverse_arbiter.sv - self-checking bench for reverse_arbiter
module tb_reverse_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, ack0, ack1;
  logic [7:0]  din0, din1, dout;
  logic        dout_valid, dout_src, dout_ready;
  logic [15:0] xfer_cnt;

  always #5 clk = ~clk;

  reverse_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .din0(din0), .ack0(ack0),
    .req1(req1), .din1(din1), .ack1(ack1),
    .dout(dout), .dout_valid(dout_valid), .dout_src(dout_src),
    .dout_ready(dout_ready), .xfer_cnt(xfer_cnt)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic        m_valid, m_last;
  logic [15:0] m_cnt;
  logic [8:0]  sb_q[$];
  logic        seen_ack0, seen_ack1;

  typedef struct {
    logic       r0, r1;
    logic [7:0] d0, d1;
    logic       rdy;
    logic       a0, a1;
    logic       v, src;
    logic [7:0] dout;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic tick(input string tag);
    logic slot_free, e0, e1, hs;
    @(negedge clk);
    slot_free = !m_valid || dout_ready;
    e0 = slot_free && req0 && (!req1 || m_last);
    e1 = slot_free && req1 && !e0;
    seen_ack0 = ack0;
    seen_ack1 = ack1;
    chk({tag, " ack0"}, ack0, e0);
    chk({tag, " ack1"}, ack1, e1);
    chk({tag, " dout_valid"}, dout_valid, m_valid);
    if (m_valid) begin
      chk({tag, " sb_depth"}, sb_q.size(), 1);
      if (sb_q.size() > 0) chk({tag, " src_dout"}, {dout_src, dout}, sb_q[0]);
    end
    hs = m_valid && dout_ready;
    if (hs) begin
      void'(sb_q.pop_front());
      m_cnt++;
    end
    if (e0 || e1) begin
      sb_q.push_back({e1, rev8(e1 ? din1 : din0)});
      m_last  = e1;
      m_valid = 1'b1;
    end else if (hs) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, " xfer_cnt"}, xfer_cnt, m_cnt);
  endtask

  // Asserts reset between edges with both requests high, then releases before the next edge.
  task automatic do_reset(input string tag);
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    #1;
    chk({tag, " rst dout"}, dout, 8'h00);
    chk({tag, " rst dout_valid"}, dout_valid, 1'b0);
    chk({tag, " rst dout_src"}, dout_src, 1'b0);
    chk({tag, " rst xfer_cnt"}, xfer_cnt, 16'h0000);
    chk({tag, " rst ack0"}, ack0, 1'b0);
    chk({tag, " rst ack1"}, ack1, 1'b0);
    m_valid = 1'b0; m_last = 1'b1; m_cnt = 16'd0;
    sb_q.delete();
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    din0 = 8'h00; din1 = 8'h00; dout_ready = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 8'hC1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h83};
    tbl[1] = '{1'b1, 1'b1, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01};
    tbl[2] = '{1'b1, 1'b1, 8'hF0, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0F};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC0};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC0};
    tbl[5] = '{1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h48};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h48};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA};

    @(posedge clk); #1;
    do_reset("init");

    // dout_ready with nothing valid must not count
    dout_ready = 1'b1;
    repeat (3) tick("idle_ready");
    chk("idle_ready cnt", xfer_cnt, 16'h0000);

    for (int i = 0; i < 8; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1;
      din0 = tbl[i].d0; din1 = tbl[i].d1;
      dout_ready = tbl[i].rdy;
      tick("vec");
      chk($sformatf("vec%0d ack0", i), seen_ack0, tbl[i].a0);
      chk($sformatf("vec%0d ack1", i), seen_ack1, tbl[i].a1);
      chk($sformatf("vec%0d valid", i), dout_valid, tbl[i].v);
      chk($sformatf("vec%0d src", i), dout_src, tbl[i].src);
      chk($sformatf("vec%0d dout", i), dout, tbl[i].dout);
    end

    do_reset("tie");
    req0 = 1'b1; req1 = 1'b1; din0 = 8'h1E; din1 = 8'h63; dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick("tie");
      chk($sformatf("tie%0d grant1", i), seen_ack1, i % 2);
      chk($sformatf("tie%0d valid", i), dout_valid, 1'b1);
      chk($sformatf("tie%0d cnt", i), xfer_cnt, i);
    end

    do_reset("bp");
    req0 = 1'b0; req1 = 1'b1; din1 = 8'h0F; dout_ready = 1'b1;
    tick("bp_load");
    chk("bp_load dout", dout, 8'hF0);
    req1 = 1'b0; req0 = 1'b1; din0 = 8'h3A; dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick("bp_hold");
      chk($sformatf("bp_hold%0d ack0", i), seen_ack0, 1'b0);
      chk($sformatf("bp_hold%0d dout", i), dout, 8'hF0);
      chk($sformatf("bp_hold%0d src", i), dout_src, 1'b1);
    end
    dout_ready = 1'b1;
    tick("bp_release");
    chk("bp_release ack0", seen_ack0, 1'b1);
    chk("bp_release dout", dout, 8'h5C);

    do_reset("wrap");
    req0 = 1'b1; din0 = 8'h96; dout_ready = 1'b1;
    tick("wrap_load");
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap ffff", xfer_cnt, 16'hFFFF);
    @(posedge clk); #1;
    chk("wrap zero", xfer_cnt, 16'h0000);
    chk("wrap valid", dout_valid, 1'b1);
    tick("wrap_after");

    do_reset("mid");
    req0 = 1'b1; din0 = 8'h2D; dout_ready = 1'b1;
    repeat (8) tick("mid_run");
    chk("mid pre cnt", xfer_cnt, 16'd7);
    chk("mid pre valid", dout_valid, 1'b1);
    #2;
    do_reset("mid");
    req0 = 1'b1; req1 = 1'b1; din0 = 8'h01; din1 = 8'h02;
    tick("mid_tie");
    chk("mid_tie ack0", seen_ack0, 1'b1);
    chk("mid_tie src", dout_src, 1'b0);
    chk("mid_tie dout", dout, 8'h80);

    do_reset("sweep");
    req0 = 1'b1; req1 = 1'b0; dout_ready = 1'b1;
    for (int v = 0; v < 256; v++) begin
      din0 = v[7:0];
      tick("sweep");
    end
    req0 = 1'b0;
    tick("sweep_drain");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reverse_arbiter.md
REVERSE_ARBITER -- requirements
Module: reverse_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, data width of each requester word and of the result.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: req0  input  1  requester 0 valid; din0 stable while req0=1 and ack0=0.
REQ-005 Port: din0  input  WIDTH  requester 0 operand.
REQ-006 Port: ack0  output  1  requester 0 accepted this cycle (combinational).
REQ-007 Port: req1  input  1  requester 1 valid; same rules as req0.
REQ-008 Port: din1  input  WIDTH  requester 1 operand.
REQ-009 Port: ack1  output  1  requester 1 accepted this cycle (combinational).
REQ-010 Port: dout  output  WIDTH  registered bit-reversed result.
REQ-011 Port: dout_valid  output  1  dout holds an unconsumed result.
REQ-012 Port: dout_src  output  1  requester index (0/1) that produced dout.
REQ-013 Port: dout_ready  input  1  consumer accepts dout this cycle.
REQ-014 Port: xfer_cnt  output  16  count of completed output handshakes.

Function
REQ-015 Reversal SHALL be dout[i] = din_g[WIDTH-1-i] for all i, din_g being the granted operand; no other transformation.
REQ-016 Output register free ("slot_free") SHALL be dout_valid=0 OR dout_ready=1.
REQ-017 load SHALL be slot_free AND (req0 OR req1); ack0/ack1 SHALL be load AND grant0/grant1, at most one high per cycle.
REQ-018 Arbitration SHALL be round-robin: single requester wins; both requesting -> grant the one not equal to last_grant.
REQ-019 On load edge: dout <= reversed din_g, dout_src <= granted index, dout_valid <= 1, last_grant <= granted index.
REQ-020 Latency: request accepted in cycle N -> result visible with dout_valid=1 in cycle N+1.
REQ-021 Output handshake = dout_valid AND dout_ready; without a simultaneous load, dout_valid SHALL clear at the next edge.
REQ-022 Simultaneous handshake and load SHALL replace dout in one edge with dout_valid held 1 (back-to-back, one result per cycle).
REQ-023 dout_valid=1 and dout_ready=0: dout, dout_src, dout_valid SHALL hold; ack0=ack1=0 regardless of requests.
REQ-024 last_grant SHALL change only on load; requests with no load SHALL not alter arbitration state.
REQ-025 xfer_cnt SHALL increment by 1 on each output handshake, wrapping 16'hFFFF -> 16'h0000.
REQ-026 dout_ready while dout_valid=0 SHALL have no effect on xfer_cnt.

Reset
REQ-027 rst=1 SHALL asynchronously force dout=0, dout_valid=0, dout_src=0, xfer_cnt=0, last_grant=1 (requester 0 wins first tie).
REQ-028 While rst=1, ack0=ack1=0; a result in flight when reset asserts SHALL be discarded.
REQ-029 First load possible on the first rising edge after rst deasserts.

Verification
REQ-030 Single request: req0=1, din0=8'b1100_0001, dout_ready=1 -> ack0 one cycle, next cycle dout=8'b1000_0011, dout_src=0, xfer_cnt=1.
REQ-031 Tie after reset: req0=req1=1 held, dout_ready=1 -> grants alternate 0,1,0,1; dout_valid stays 1 every cycle; xfer_cnt counts each.
REQ-032 Backpressure: dout valid with 8'hF0 from din1=8'h0F, dout_ready=0 for 5 cycles with req0=1 -> ack0=0 and dout stable; dout_ready=1 -> ack0 same cycle, dout updates next edge.
REQ-033 Wrap: force 65536 handshakes -> xfer_cnt returns to 0 without disturbing dout_valid.
REQ-034 Reset mid-operation: dout_valid=1, xfer_cnt=7, assert rst between edges -> all outputs zero immediately; after release req1 and req0 tie -> requester 0 granted.
REQ-035 Width/reversal sweep: all 256 values of din0 with WIDTH=8 -> dout equals bit-reversed operand each time.
